// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the instruction ROM address combinationally
// and registers the returned word into a valid/ready handshake toward decode.
module instr_fetch #(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          INSTR_WIDTH = 9,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   halt,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic [ADDR_WIDTH-1:0]  instr_addr,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic                   done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(RESET_PC);

  logic [1:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   valid_q, valid_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  opc_q, opc_d;
  logic                   done_q;
  logic                   xfer;

  assign xfer       = valid_q && out_ready;
  assign instr_addr = pc_q;
  assign out_valid  = valid_q;
  assign out_instr  = instr_q;
  assign out_pc     = opc_q;
  assign done       = done_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    case (state_q)
      S_FETCH: begin
        // A redirect flushes the wrong-path word even if decode takes it this cycle.
        if (branch_taken) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
        end else if (halt) begin
          state_d = S_HALTED;
          if (xfer) valid_d = 1'b0;
        end else if (!valid_q || out_ready) begin
          instr_d = instr_in;
          opc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        // IDLE and HALTED: a held word drains normally while waiting for start.
        if (xfer) valid_d = 1'b0;
        if (start) begin
          state_d = S_FETCH;
          pc_d    = PC_RST;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RST;
      valid_q <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      done_q  <= (state_d == S_HALTED);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table for the documented scenarios,
// an asynchronous mid-stream reset, then randomized traffic against a reference model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt, branch_taken, out_ready;
  logic [11:0] branch_target;
  logic [11:0] instr_addr;
  logic [8:0]  instr_in;
  logic        out_valid;
  logic [8:0]  out_instr;
  logic [11:0] out_pc;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ROM contents: address+1 for low addresses, scrambled higher up.
  function automatic logic [8:0] rom_val(input logic [11:0] a);
    return 9'(a + 12'd1) ^ {a[11:9], a[8:3]};
  endfunction

  assign instr_in = rom_val(instr_addr);

  instr_fetch #(.ADDR_WIDTH(12), .INSTR_WIDTH(9), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_addr(instr_addr), .instr_in(instr_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        st, hl, br;
    logic [11:0] tgt;
    logic        rdy;
    logic        ev;
    logic [11:0] epc;
    logic [11:0] eaddr;
    logic        edone;
  } vec_t;

  function automatic vec_t mk(input logic st, hl, br, input logic [11:0] tgt, input logic rdy,
                              input logic ev, input logic [11:0] epc, eaddr, input logic edone);
    vec_t v;
    v.st = st; v.hl = hl; v.br = br; v.tgt = tgt; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.edone = edone;
    return v;
  endfunction

  vec_t tbl[24];

  // Reference model state (mode: 0 idle, 1 fetching, 2 halted)
  int          m_mode;
  int          m_pc;
  bit          m_v;
  int          m_opc;
  logic [8:0]  m_instr;

  task automatic model_step(input bit st, hl, br, rdy, input int tgt);
    bit taken;
    taken = m_v && rdy;
    if (m_mode == 1) begin
      if (br) begin
        m_pc = tgt;
        m_v  = 0;
      end else if (hl) begin
        m_mode = 2;
        if (taken) m_v = 0;
      end else if (!m_v || rdy) begin
        m_instr = rom_val(12'(m_pc));
        m_opc   = m_pc;
        m_v     = 1;
        m_pc    = (m_pc + 1) % 4096;
      end
    end else begin
      if (taken) m_v = 0;
      if (st) begin
        m_mode = 1;
        m_pc   = 0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 0; halt = 0; branch_taken = 0; branch_target = '0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_instr", 32'(out_instr), 0);
    chk("reset_pc",    32'(out_pc), 0);
    chk("reset_done",  32'(done), 0);
    chk("reset_addr",  32'(instr_addr), 0);
    rst_n = 1'b1;

    //            st hl br tgt      rdy ev epc      eaddr    done
    tbl[0]  = mk(1, 0, 0, 12'h000, 1, 0, 12'h000, 12'h000, 0);
    tbl[1]  = mk(0, 0, 0, 12'h000, 1, 1, 12'h000, 12'h001, 0);
    tbl[2]  = mk(0, 0, 0, 12'h000, 1, 1, 12'h001, 12'h002, 0);
    tbl[3]  = mk(0, 0, 0, 12'h000, 1, 1, 12'h002, 12'h003, 0);
    tbl[4]  = mk(0, 0, 0, 12'h000, 0, 1, 12'h002, 12'h003, 0);
    tbl[5]  = mk(0, 0, 0, 12'h000, 0, 1, 12'h002, 12'h003, 0);
    tbl[6]  = mk(0, 0, 0, 12'h000, 0, 1, 12'h002, 12'h003, 0);
    tbl[7]  = mk(0, 0, 0, 12'h000, 1, 1, 12'h003, 12'h004, 0);
    tbl[8]  = mk(0, 0, 0, 12'h000, 1, 1, 12'h004, 12'h005, 0);
    tbl[9]  = mk(0, 0, 0, 12'h000, 1, 1, 12'h005, 12'h006, 0);
    tbl[10] = mk(0, 0, 1, 12'h0A0, 0, 0, 12'h000, 12'h0A0, 0);
    tbl[11] = mk(0, 0, 0, 12'h000, 1, 1, 12'h0A0, 12'h0A1, 0);
    tbl[12] = mk(0, 1, 1, 12'hFFE, 1, 0, 12'h000, 12'hFFE, 0);
    tbl[13] = mk(0, 0, 0, 12'h000, 1, 1, 12'hFFE, 12'hFFF, 0);
    tbl[14] = mk(0, 0, 0, 12'h000, 1, 1, 12'hFFF, 12'h000, 0);
    tbl[15] = mk(0, 0, 0, 12'h000, 1, 1, 12'h000, 12'h001, 0);
    tbl[16] = mk(0, 0, 0, 12'h000, 1, 1, 12'h001, 12'h002, 0);
    tbl[17] = mk(0, 1, 0, 12'h000, 0, 1, 12'h001, 12'h002, 1);
    tbl[18] = mk(0, 0, 0, 12'h000, 0, 1, 12'h001, 12'h002, 1);
    tbl[19] = mk(0, 0, 0, 12'h000, 1, 0, 12'h000, 12'h002, 1);
    tbl[20] = mk(0, 0, 0, 12'h000, 1, 0, 12'h000, 12'h002, 1);
    tbl[21] = mk(1, 0, 0, 12'h000, 1, 0, 12'h000, 12'h000, 0);
    tbl[22] = mk(0, 0, 0, 12'h000, 1, 1, 12'h000, 12'h001, 0);
    tbl[23] = mk(0, 0, 0, 12'h000, 1, 1, 12'h001, 12'h002, 0);

    for (int i = 0; i < 24; i++) begin
      start = tbl[i].st; halt = tbl[i].hl; branch_taken = tbl[i].br;
      branch_target = tbl[i].tgt; out_ready = tbl[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_addr", i), 32'(instr_addr), 32'(tbl[i].eaddr));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].edone));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_pc", i), 32'(out_pc), 32'(tbl[i].epc));
        chk($sformatf("vec%0d_instr", i), 32'(out_instr), 32'(rom_val(tbl[i].epc)));
      end
    end

    // Asynchronous reset mid-stream: outputs clear without waiting for a clock edge.
    start = 0; halt = 0; branch_taken = 0; out_ready = 0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_addr",  32'(instr_addr), 0);
    chk("midrst_pc",    32'(out_pc), 0);
    chk("midrst_done",  32'(done), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    m_mode = 0; m_pc = 0; m_v = 0; m_opc = 0; m_instr = '0;
    for (int c = 0; c < 600; c++) begin
      bit st, hl, br, rdy;
      int tgt;
      st  = ($urandom_range(0, 7) == 0);
      hl  = ($urandom_range(0, 15) == 0);
      br  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tgt = ($urandom_range(0, 1) == 0) ? int'($urandom_range(4092, 4095))
                                        : int'($urandom_range(0, 4095));
      start = st; halt = hl; branch_taken = br; out_ready = rdy;
      branch_target = 12'(tgt);
      model_step(st, hl, br, rdy, tgt);
      @(posedge clk);
      #1;
      chk("rnd_valid", 32'(out_valid), 32'(m_v));
      chk("rnd_addr",  32'(instr_addr), 32'(m_pc));
      chk("rnd_done",  32'(done), 32'(m_mode == 2));
      if (m_v) begin
        chk("rnd_pc",    32'(out_pc), 32'(m_opc));
        chk("rnd_instr", 32'(out_instr), 32'(m_instr));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
